// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with blocking miss fill.
// Ports: CLK/nRST, fetch side (imemREN, imemaddr, iflush, ihit, imemload),
//   arbiter side (iREN, iaddr, iload, iwait), counters (hitcnt, misscnt).
module icache_direct #(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    output logic [15:0] hitcnt,
    output logic [15:0] misscnt
);

    localparam int IDX  = $clog2(NSETS);
    localparam int TAGW = 30 - IDX;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state;
    logic [NSETS-1:0]  valid;
    logic [TAGW-1:0]   tagmem  [NSETS];
    logic [31:0]       datamem [NSETS];
    logic [29:0]       missaddr;

    logic [IDX-1:0]    idx;
    logic [TAGW-1:0]   tag;
    logic [IDX-1:0]    midx;
    logic [TAGW-1:0]   mtag;
    logic              lookup_hit;
    logic              fill_we;
    logic              unused_lsb;

    assign idx  = imemaddr[IDX+1:2];
    assign tag  = imemaddr[31:IDX+2];
    assign midx = missaddr[IDX-1:0];
    assign mtag = missaddr[29:IDX];

    assign unused_lsb = ^imemaddr[1:0];

    // A flush in the same cycle suppresses the hit.
    assign lookup_hit = (state == IDLE) && imemREN && !iflush &&
                        valid[idx] && (tagmem[idx] == tag);

    assign ihit     = lookup_hit;
    assign imemload = lookup_hit ? datamem[idx] : 32'd0;
    assign iREN     = (state == FILL);
    assign iaddr    = (state == FILL) ? {missaddr, 2'b00} : 32'd0;

    // Reset forces IDLE asynchronously, so no write can land mid-reset.
    assign fill_we = (state == FILL) && !iwait && !iflush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            valid    <= '0;
            missaddr <= '0;
            hitcnt   <= '0;
            misscnt  <= '0;
        end else if (iflush) begin
            valid <= '0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN) begin
                        if (lookup_hit) begin
                            if (hitcnt != 16'hFFFF)
                                hitcnt <= hitcnt + 16'd1;
                        end else begin
                            missaddr <= imemaddr[31:2];
                            if (misscnt != 16'hFFFF)
                                misscnt <= misscnt + 16'd1;
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        valid[midx] <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tagmem[midx]  <= mtag;
            datamem[midx] <= iload;
        end
    end

endmodule

// File: doc/icache_direct.md
ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 Parameter: NSETS, default 16, number of one-word direct-mapped lines; SHALL be a power of two, 2..256.
REQ-002 Port: CLK  input  1  clock; all state updates on rising edge.
REQ-003 Port: nRST  input  1  asynchronous, active-low reset.
REQ-004 Port: imemREN  input  1  datapath instruction-fetch request.
REQ-005 Port: imemaddr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 Port: iflush  input  1  invalidate all lines.
REQ-007 Port: ihit  output  1  imemload valid this cycle.
REQ-008 Port: imemload  output  32  fetched instruction word.
REQ-009 Port: iREN  output  1  read request to memory arbiter.
REQ-010 Port: iaddr  output  32  word-aligned fill address to arbiter.
REQ-011 Port: iload  input  32  read data from arbiter.
REQ-012 Port: iwait  input  1  arbiter busy; iload valid in any cycle where iREN=1 and iwait=0.
REQ-013 Port: hitcnt  output  16  saturating hit counter.
REQ-014 Port: misscnt  output  16  saturating miss counter.

Function
REQ-015 Address split: IDX = log2(NSETS); index = imemaddr[IDX+1:2], tag = imemaddr[31:IDX+2].
REQ-016 Per line: valid bit, tag, 32-bit data; storage is flops, no reset on tag/data.
REQ-017 FSM states: IDLE and FILL.
REQ-018 IDLE hit: imemREN=1, line valid, tags equal -> ihit=1, imemload=line data, same cycle (combinational); hitcnt increments.
REQ-019 IDLE miss: imemREN=1 and not a hit -> ihit=0; latch {imemaddr[31:2],2'b00} into the miss register; misscnt increments; next state FILL.
REQ-020 IDLE with imemREN=0: ihit=0, iREN=0, no state change.
REQ-021 FILL: iREN=1, iaddr=miss register, ihit=0; imemaddr and imemREN are ignored.
REQ-022 FILL, iwait=0: write line at the miss index with valid=1, miss tag, data=iload; next state IDLE; the refetch hits on the following cycle.
REQ-023 FILL, iwait=1: remain in FILL with no timeout.
REQ-024 Miss latency: 1 detect cycle + fill cycles until iwait=0 + 1 hit cycle.
REQ-025 iflush=1: clear all valid bits at the next edge; in FILL it aborts the fill, with no line write and next state IDLE; iREN is still driven during the flush cycle.
REQ-026 iflush has priority over a hit or miss in the same cycle: ihit=0, no counter change, state stays IDLE.
REQ-027 Counters: 16-bit, saturate at 16'hFFFF, and never wrap.
REQ-028 Outside FILL: iREN=0, iaddr=0; when ihit=0, imemload=0.

Reset
REQ-029 nRST=0 asynchronously forces: state IDLE, all valid=0, miss register=0, hitcnt=0, misscnt=0; outputs ihit=0, iREN=0, iaddr=0, imemload=0.
REQ-030 Reset during FILL abandons the fill: iREN deasserts immediately and no line is written.

Verification
REQ-031 Cold fetch 0x00000040, NSETS=16, iwait=1 for 3 cycles then 0 with iload=0x8C220004 -> iREN=1 and iaddr=0x40 for 4 cycles; the next cycle has ihit=1, imemload=0x8C220004, misscnt=1, hitcnt=1.
REQ-032 Conflict: fill 0x00000040, then fetch 0x00000080 (same index 0, different tag) -> miss and fill; a later fetch of 0x40 misses again; misscnt=3.
REQ-033 Change imemaddr to 0x100 during a fill of 0x40 -> iaddr stays 0x40; after the fill, index 0 holds tag 0x1; fetch 0x100 then misses.
REQ-034 Assert iflush in the second FILL cycle -> next cycle is IDLE with iREN=0; a refetch misses; previously valid lines miss.
REQ-035 Force hitcnt=0xFFFE, then issue 3 consecutive hits -> hitcnt=0xFFFF and holds.
REQ-036 Drop nRST mid-FILL -> iREN=0 within the same cycle; after release, all fetches miss and counters are 0.
